// File: rtl/cpu_defs_pkg.sv
// Shared CPU front-end definitions: fetch queue entry payload and default depth.
package cpu_defs_pkg;

  localparam int unsigned IQ_DEPTH = 8;
  localparam int unsigned IQ_PC_W  = 32;

  typedef struct packed {
    logic [IQ_PC_W-1:0] pc;
    logic [IQ_PC_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: absorbs 0/1/2 instructions per fetch response and
// presents the two oldest entries to dual-issue decode each cycle.
module inst_fetch_queue
  import cpu_defs_pkg::*;
#(
  parameter int unsigned DEPTH = IQ_DEPTH,
  parameter int unsigned PC_W  = IQ_PC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [PC_W-1:0]          fetch_pc,
  input  logic                     inst_ok,
  input  logic                     inst_ok_1,
  input  logic                     inst_ok_2,
  input  logic [PC_W-1:0]          inst_data_1,
  input  logic [PC_W-1:0]          inst_data_2,
  output logic                     fetch_ready,
  output logic                     deq_valid_1,
  output logic [PC_W-1:0]          deq_pc_1,
  output logic [PC_W-1:0]          deq_inst_1,
  output logic                     deq_valid_2,
  output logic [PC_W-1:0]          deq_pc_2,
  output logic [PC_W-1:0]          deq_inst_2,
  input  logic [1:0]               issue_num,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = IDX_W + 1;

  fetch_entry_t mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_ptr_next, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_1, wr_ptr_1;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] push_n, pop_n;
  logic [1:0]       issue_eff;
  logic             push_ok;
  logic             wr_en_1, wr_en_2;
  fetch_entry_t     entry_1, entry_2;

  // Next-state: pop from registered occupancy, push only into guaranteed-free slots.
  always_comb begin
    issue_eff   = (issue_num == 2'd3) ? 2'd2 : issue_num;
    pop_n       = (CNT_W'(issue_eff) > count) ? count : CNT_W'(issue_eff);
    push_ok     = inst_ok && fetch_ready && inst_ok_1;
    push_n      = push_ok ? (inst_ok_2 ? CNT_W'(2) : CNT_W'(1)) : CNT_W'(0);
    wr_en_1     = push_ok && !flush;
    wr_en_2     = push_ok && inst_ok_2 && !flush;
    entry_1     = '{pc: fetch_pc, inst: inst_data_1};
    entry_2     = '{pc: fetch_pc + PC_W'(4), inst: inst_data_2};
    rd_ptr_1    = rd_ptr + PTR_W'(1);
    wr_ptr_1    = wr_ptr + PTR_W'(1);
    rd_ptr_next = rd_ptr + PTR_W'(pop_n);
    wr_ptr_next = wr_ptr + PTR_W'(push_n);
    count_next  = count + push_n - pop_n;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end
  end

  // Pointer/count state and storage; storage is deliberately left uncleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
      if (wr_en_1) mem[wr_ptr[IDX_W-1:0]]   <= entry_1;
      if (wr_en_2) mem[wr_ptr_1[IDX_W-1:0]] <= entry_2;
    end
  end

  assign fetch_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
  assign deq_valid_1 = count >= CNT_W'(1);
  assign deq_valid_2 = count >= CNT_W'(2);
  assign deq_pc_1    = mem[rd_ptr[IDX_W-1:0]].pc;
  assign deq_inst_1  = mem[rd_ptr[IDX_W-1:0]].inst;
  assign deq_pc_2    = mem[rd_ptr_1[IDX_W-1:0]].pc;
  assign deq_inst_2  = mem[rd_ptr_1[IDX_W-1:0]].inst;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_inst_fetch_queue;
  import cpu_defs_pkg::*;

  localparam int DEPTH = IQ_DEPTH;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic [31:0]       fetch_pc = '0;
  logic              inst_ok = 1'b0, inst_ok_1 = 1'b0, inst_ok_2 = 1'b0;
  logic [31:0]       inst_data_1 = '0, inst_data_2 = '0;
  logic              fetch_ready;
  logic              deq_valid_1, deq_valid_2;
  logic [31:0]       deq_pc_1, deq_inst_1, deq_pc_2, deq_inst_2;
  logic [1:0]        issue_num = '0;
  logic [CNT_W-1:0]  count;

  int tests = 0;
  int fails = 0;
  fetch_entry_t q[$];
  logic [31:0] pc_gen;

  inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_pc(fetch_pc),
    .inst_ok(inst_ok), .inst_ok_1(inst_ok_1), .inst_ok_2(inst_ok_2),
    .inst_data_1(inst_data_1), .inst_data_2(inst_data_2),
    .fetch_ready(fetch_ready),
    .deq_valid_1(deq_valid_1), .deq_pc_1(deq_pc_1), .deq_inst_1(deq_inst_1),
    .deq_valid_2(deq_valid_2), .deq_pc_2(deq_pc_2), .deq_inst_2(deq_inst_2),
    .issue_num(issue_num), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Compare every visible output against the model queue.
  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("count_le_depth", 32'(count <= CNT_W'(DEPTH)), 32'd1);
    chk("fetch_ready", 32'(fetch_ready), 32'((DEPTH - q.size()) >= 2));
    chk("deq_valid_1", 32'(deq_valid_1), 32'(q.size() >= 1));
    chk("deq_valid_2", 32'(deq_valid_2), 32'(q.size() >= 2));
    if (q.size() >= 1) begin
      chk("deq_pc_1", deq_pc_1, q[0].pc);
      chk("deq_inst_1", deq_inst_1, q[0].inst);
    end
    if (q.size() >= 2) begin
      chk("deq_pc_2", deq_pc_2, q[1].pc);
      chk("deq_inst_2", deq_inst_2, q[1].inst);
    end
  endtask

  task automatic drive(input logic ok, input logic ok1, input logic ok2, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] iss,
                       input logic fl);
    inst_ok = ok; inst_ok_1 = ok1; inst_ok_2 = ok2;
    fetch_pc = pc; inst_data_1 = d1; inst_data_2 = d2;
    issue_num = iss; flush = fl;
  endtask

  // Apply the current inputs to the model, take one clock edge, then check.
  task automatic step();
    int pop;
    bit rdy;
    rdy = (DEPTH - q.size()) >= 2;
    if (flush) begin
      q.delete();
    end else begin
      pop = (issue_num == 2'd3) ? 2 : int'(issue_num);
      if (pop > q.size()) pop = q.size();
      repeat (pop) void'(q.pop_front());
      if (inst_ok && rdy && inst_ok_1) begin
        q.push_back('{pc: fetch_pc, inst: inst_data_1});
        if (inst_ok_2) q.push_back('{pc: fetch_pc + 32'd4, inst: inst_data_2});
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'd0, 1'b0);
  endtask

  task automatic dual_push(input logic [31:0] pc, input logic [1:0] iss);
    drive(1'b1, 1'b1, 1'b1, pc, $urandom, $urandom, iss, 1'b0);
    step();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd1);
    chk("rst_valid_1", 32'(deq_valid_1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();
    step();

    // Single push then pop
    drive(1'b1, 1'b1, 1'b0, 32'hBFC00000, 32'h24080001, '0, 2'd0, 1'b0);
    step();
    chk("single_pc", deq_pc_1, 32'hBFC00000);
    chk("single_cnt", 32'(count), 32'd1);
    idle(); issue_num = 2'd1;
    step();
    chk("single_empty", 32'(deq_valid_1), 32'd0);

    // Dual push then dual pop
    drive(1'b1, 1'b1, 1'b1, 32'h80000010, 32'hAAAA0001, 32'hBBBB0002, 2'd0, 1'b0);
    step();
    chk("dual_pc2", deq_pc_2, 32'h80000014);
    idle(); issue_num = 2'd2;
    step();

    // Fill and back-pressure
    pc_gen = 32'h00001000;
    repeat (3) begin dual_push(pc_gen, 2'd0); pc_gen += 8; end
    chk("fill_6", 32'(count), 32'd6);
    dual_push(pc_gen, 2'd0); pc_gen += 8;
    chk("fill_8_ready", 32'(fetch_ready), 32'd0);
    dual_push(pc_gen, 2'd0);
    chk("drop_8", 32'(count), 32'd8);
    idle(); issue_num = 2'd1; step();
    chk("pop_7_ready", 32'(fetch_ready), 32'd0);
    idle(); issue_num = 2'd1; step();
    chk("pop_6_ready", 32'(fetch_ready), 32'd1);
    idle(); issue_num = 2'd3; repeat (3) step();

    // Wrap with simultaneous push/pop
    pc_gen = 32'h80001000;
    repeat (20) begin dual_push(pc_gen, 2'd2); pc_gen += 8; end
    chk("wrap_cnt", 32'(count), 32'd2);
    idle(); issue_num = 2'd2; step();

    // Over-issue, and flush beating push+pop
    drive(1'b1, 1'b1, 1'b0, 32'h4000, 32'h1, '0, 2'd0, 1'b0); step();
    idle(); issue_num = 2'd2; step();
    chk("over_issue", 32'(count), 32'd0);
    dual_push(32'h5000, 2'd0); dual_push(32'h5008, 2'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h5010, 32'h7, '0, 2'd0, 1'b0); step();
    chk("cnt_5", 32'(count), 32'd5);
    drive(1'b1, 1'b1, 1'b1, 32'h5014, 32'h8, 32'h9, 2'd2, 1'b1); step();
    chk("flush_valid", 32'(deq_valid_1), 32'd0);

    // PC wrap-around at the top of the address space
    idle(); dual_push(32'hFFFFFFFC, 2'd0);
    chk("pc_wrap", deq_pc_2, 32'h00000000);
    idle(); issue_num = 2'd2; step();

    // Random traffic with an asynchronous reset mid-burst
    pc_gen = 32'h9FC00000;
    for (int i = 0; i < 400; i++) begin
      logic ok1;
      ok1 = ($urandom_range(0, 9) < 8);
      drive(($urandom_range(0, 9) < 8), ok1, ok1 && $urandom_range(0, 1) == 1,
            pc_gen, $urandom, $urandom, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 3));
      pc_gen += 8;
      if (i == 200) begin
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ready", 32'(fetch_ready), 32'd1);
        chk("arst_valid", 32'(deq_valid_1), 32'd0);
        q.delete();
        #2;
        rst = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
